// File: rtl/model.sv
// Four-tap moving-average filter on an 8-bit unsigned stream.
// The output is registered, so new input appears in the result one clock later.
module model (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in1,
  output logic [7:0] out1
);

  logic [7:0] r_h0;
  logic [7:0] r_h1;
  logic [7:0] r_h2;
  logic [7:0] r_out;
  logic [9:0] w_sum;

  // The sum is 10 bits wide, so four samples of 255 (1020) cannot wrap.
  assign w_sum = 10'(in1) + 10'(r_h0) + 10'(r_h1) + 10'(r_h2);

  // NOTE: use non-blocking assignments here. Every register then sees the
  // history from before the clock edge, and the shift and the sum stay
  // consistent with each other regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h0  <= '0;
      r_h1  <= '0;
      r_h2  <= '0;
      r_out <= '0;
    end else begin
      r_h0  <= in1;
      r_h1  <= r_h0;
      r_h2  <= r_h1;
      r_out <= w_sum[9:2];
    end
  end

  assign out1 = r_out;

endmodule

// File: tb/tb_model.sv
// Self-checking bench for the moving-average filter. Directed cases come first,
// then randomized samples compared against a sliding-window reference model.
module tb_model;

  logic       clk;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] out1;

  int vectors;
  int miscompares;
  int window[$];   // last four samples seen by the filter, oldest first

  model dut (
    .clk  (clk),
    .rst  (rst),
    .in1  (in1),
    .out1 (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    window.delete();
    for (int i = 0; i < 4; i++) window.push_back(0);
  endfunction

  // Average of the last four samples, including the new one, truncated.
  function automatic int model_push(input int v);
    int sum;
    window.push_back(v);
    void'(window.pop_front());
    sum = 0;
    foreach (window[i]) sum += window[i];
    return sum / 4;
  endfunction

  // Apply one sample and check the result one clock edge later.
  // If lit is -1, only the model is checked. Otherwise the literal is checked too.
  task automatic step(input logic [7:0] v, input string tag, input int lit);
    int exp;
    in1 = v;
    @(posedge clk);
    #1;
    exp = model_push(int'(v));
    check(tag, out1, 8'(exp));
    if (lit >= 0) check({tag, "_lit"}, out1, 8'(lit));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_out", out1, 8'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ramp_exp[8] = '{0, 0, 1, 2, 3, 4, 5, 6};
    int fs_up[4]    = '{63, 127, 191, 255};
    int fs_dn[4]    = '{191, 127, 63, 0};

    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    in1 = 8'd200;
    model_clear();

    // While reset is held, the output stays at zero across clock edges.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", out1, 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(8'd200, "rst_first", 50);

    // A step input climbs to its final value in four edges and then holds.
    do_reset();
    for (int i = 1; i <= 6; i++) step(8'd4, "step", (i < 4) ? i : 4);

    // Ramp input.
    do_reset();
    for (int i = 0; i < 8; i++) step(8'(i + 1), "ramp", ramp_exp[i]);

    // Full-scale input, then the decay back to zero.
    do_reset();
    for (int i = 0; i < 4; i++) step(8'd255, "fs_up", fs_up[i]);
    for (int i = 0; i < 4; i++) step(8'd0, "fs_dn", fs_dn[i]);

    // Truncation: 3 alone gives 0, and 3 + 1 = 4 gives 1.
    do_reset();
    step(8'd3, "trunc0", 0);
    step(8'd1, "trunc1", 1);

    // Reset asserted between clock edges, in the middle of a sequence.
    do_reset();
    for (int i = 0; i < 5; i++) step(8'd255, "mid_fill", -1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_async", out1, 8'd0);
    model_clear();
    #1;
    rst = 1'b0;
    step(8'd255, "mid_after", 63);

    // Randomized stream, with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check("rand_rst", out1, 8'd0);
        model_clear();
        #1;
        rst = 1'b0;
      end
      step(8'($urandom_range(0, 255)), "rand", -1);
    end

    // A constant held for at least four edges reproduces that value exactly.
    for (int v = 0; v < 256; v += 51) begin
      for (int k = 0; k < 4; k++) step(8'(v), "const", (k == 3) ? v : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/model.md
MODEL -- requirements
Module: model

Interface
REQ-001 Ports SHALL be: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset); in1 input 8 (unsigned sample); out1 output 8 (unsigned filtered result).
REQ-002 The block SHALL have exactly one clock (clk), and reset (rst) SHALL be asynchronous and active-high.
REQ-003 The block SHALL have no parameters; the data width is fixed at 8 bits.

Function
REQ-004 The block SHALL be a 4-tap moving-average filter of in1.
REQ-005 The block SHALL sample in1 on every rising edge of clk; there is no enable or valid handshake.
REQ-006 The block SHALL hold a 3-entry history h0..h2 of the most recent prior samples, h0 being the newest.
REQ-007 On each rising edge, history SHALL shift: h0 <= in1, h1 <= h0, h2 <= h1.
REQ-008 On each rising edge, out1 SHALL load floor((in1 + h0 + h1 + h2) / 4) using pre-edge history values.
REQ-009 The sum SHALL be computed at 10 bits unsigned, so no intermediate overflow occurs; the maximum sum is 1020.
REQ-010 Division SHALL be a truncating right shift by 2, with no rounding.
REQ-011 out1 SHALL be driven directly from a register, with no combinational path from in1 to out1.
REQ-012 Latency SHALL be one clock: a change on in1 affects out1 after the next rising edge.
REQ-013 A constant input value V held for 4 or more edges SHALL yield out1 = V, exactly, for any V in 0..255.
REQ-014 out1 SHALL never exceed 255, and no saturation logic is required.
REQ-015 in1 SHALL be treated as unsigned; X/Z on in1 is not required to be handled.

Reset
REQ-016 While rst = 1, h0, h1, h2 and out1 SHALL be 0, independent of clk.
REQ-017 Assertion of rst SHALL clear all state immediately, with no wait for a clock edge, including in the middle of a sequence.
REQ-018 After rst deasserts, the first rising edge SHALL produce out1 = floor(in1 / 4), because the history is zero.
REQ-019 Reset SHALL be the only means of clearing the history.

Verification
REQ-020 Reset check: assert rst with in1 = 200 and toggle clk -> out1 = 0 throughout; deassert rst, then 1 edge -> out1 = 50.
REQ-021 Step check: after reset, in1 = 4 held -> out1 = 1, 2, 3, 4 on edges 1 through 4, then remains 4.
REQ-022 Ramp check: after reset, in1 = 1, 2, 3, 4, 5, 6, 7, 8 on successive edges -> out1 = 0, 0, 1, 2, 3, 4, 5, 6.
REQ-023 Full-scale check: after reset, in1 = 255 for 4 edges -> out1 = 63, 127, 191, 255; then in1 = 0 -> out1 = 191, 127, 63, 0.
REQ-024 Mid-operation reset: with in1 = 255 at steady state, pulse rst between edges -> out1 = 0 immediately; the next edge gives 63.
REQ-025 Truncation check: after reset, in1 = 3 for 1 edge -> out1 = 0; then in1 = 1 -> out1 = 1, because the sum 4 divided by 4 is 1.
